// File: rtl/uv_nb_ctx_pkg.sv
// Shared constants, FSM encoding and recon byte helpers for the UV neighbour-context engine.
package uv_nb_ctx_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned ROW_W    = 64;
  localparam int unsigned LINE_W   = 128;
  localparam int unsigned RECON_W  = 1024;

  // Byte offsets inside the 128-byte U/V reconstruction
  localparam int unsigned U_BASE   = 0;
  localparam int unsigned V_BASE   = 64;
  localparam int unsigned BOT_OFF  = 56;

  // VP8 substitutes for missing neighbours
  localparam logic [BYTE_W-1:0] TOP_EDGE  = 8'h7F;
  localparam logic [BYTE_W-1:0] LEFT_EDGE = 8'h81;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    LATCH = 2'd2,
    WR    = 2'd3
  } state_e;

  // Eight consecutive bytes starting at byte index base (one row of a plane)
  function automatic logic [ROW_W-1:0] recon_row(input logic [RECON_W-1:0] r,
                                                 input int unsigned base);
    return r[BYTE_W*base +: ROW_W];
  endfunction

  // Rightmost byte of each row of a plane; byte i of the result is row i
  function automatic logic [ROW_W-1:0] recon_rcol(input logic [RECON_W-1:0] r,
                                                  input int unsigned base);
    logic [ROW_W-1:0] col;
    col = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      col[BYTE_W*i +: BYTE_W] = r[BYTE_W*(base + 8*i + 7) +: BYTE_W];
    end
    return col;
  endfunction

endpackage

// File: rtl/uv_top_line_ram.sv
// Top-line store: one bottom U/V row per macroblock column, registered read.
module uv_top_line_ram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port and synchronous read port; contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uv_nb_ctx.sv
// Chroma neighbour-context engine: fetches top/left/corner context per macroblock
// and absorbs the committed reconstruction for later macroblocks.
module uv_nb_ctx
  import uv_nb_ctx_pkg::*;
#(
  parameter int unsigned MAX_MB_W = 1024,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_mb,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          commit,
  input  logic [1023:0] recon,
  output logic [63:0]   top_u,
  output logic [63:0]   top_v,
  output logic [63:0]   left_u,
  output logic [63:0]   left_v,
  output logic [7:0]    top_left_u,
  output logic [7:0]    top_left_v,
  output logic          ctx_valid,
  output logic          busy,
  output logic          proto_err
);

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]   pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic                 pend_q, pend_d;
  logic [LINE_W-1:0]    bot_q, bot_d;
  logic [ROW_W-1:0]     rcol_u_q, rcol_u_d, rcol_v_q, rcol_v_d;
  logic [ROW_W-1:0]     lreg_u_q, lreg_u_d, lreg_v_q, lreg_v_d;
  logic [BYTE_W-1:0]    tl_u_q, tl_u_d, tl_v_q, tl_v_d;
  logic [ROW_W-1:0]     top_u_q, top_u_d, top_v_q, top_v_d;
  logic [ROW_W-1:0]     left_u_q, left_u_d, left_v_q, left_v_d;
  logic [BYTE_W-1:0]    top_left_u_q, top_left_u_d, top_left_v_q, top_left_v_d;
  logic                 ctx_valid_q, ctx_valid_d, busy_q, busy_d, proto_err_q, proto_err_d;

  logic                 capture, load_left, do_latch, ram_re, ram_we, take_pend, start_to_pend;
  logic [LINE_W-1:0]    ram_rdata;
  logic [ROW_W-1:0]     row_u, row_v;

  assign row_u = ram_rdata[ROW_W-1:0];
  assign row_v = ram_rdata[LINE_W-1:ROW_W];

  uv_top_line_ram #(
    .DEPTH  (MAX_MB_W),
    .ADDR_W (ADDR_W),
    .DATA_W (LINE_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ADDR_W'(x_q)),
    .wdata (bot_q),
    .re    (ram_re),
    .raddr (ADDR_W'(x_q)),
    .rdata (ram_rdata)
  );

  // Next-state, request bookkeeping and protocol checking
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    pend_d      = pend_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    proto_err_d = proto_err_q;
    capture     = 1'b0;
    load_left   = 1'b0;
    do_latch    = 1'b0;
    ram_re      = 1'b0;
    ram_we      = 1'b0;
    take_pend   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (commit) begin
          capture = 1'b1;
          state_d = WR;
        end else if (pend_q) begin
          x_d       = pend_x_q;
          y_d       = pend_y_q;
          take_pend = 1'b1;
          state_d   = RD;
        end else if (start_mb) begin
          x_d     = x;
          y_d     = y;
          state_d = RD;
        end
      end
      RD: begin
        ram_re  = 1'b1;
        state_d = LATCH;
        if (commit) proto_err_d = 1'b1;
      end
      LATCH: begin
        do_latch = 1'b1;
        state_d  = IDLE;
        if (commit) proto_err_d = 1'b1;
      end
      WR: begin
        ram_we    = 1'b1;
        load_left = 1'b1;
        if (pend_q) begin
          x_d       = pend_x_q;
          y_d       = pend_y_q;
          take_pend = 1'b1;
          state_d   = RD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any start that is not launched directly goes to the single pending slot
    start_to_pend = start_mb && !(state_q == IDLE && !commit && !pend_q);
    if (take_pend) pend_d = 1'b0;
    if (start_to_pend) begin
      if (pend_q) begin
        proto_err_d = 1'b1;
      end else begin
        pend_d   = 1'b1;
        pend_x_d = x;
        pend_y_d = y;
      end
    end

    ctx_valid_d = (state_q == LATCH);
    busy_d      = (state_d != IDLE);
  end

  // Recon capture, left-column update and context output formation
  always_comb begin
    bot_d        = bot_q;
    rcol_u_d     = rcol_u_q;
    rcol_v_d     = rcol_v_q;
    lreg_u_d     = lreg_u_q;
    lreg_v_d     = lreg_v_q;
    tl_u_d       = tl_u_q;
    tl_v_d       = tl_v_q;
    top_u_d      = top_u_q;
    top_v_d      = top_v_q;
    left_u_d     = left_u_q;
    left_v_d     = left_v_q;
    top_left_u_d = top_left_u_q;
    top_left_v_d = top_left_v_q;

    if (capture) begin
      bot_d    = {recon_row(recon, V_BASE + BOT_OFF), recon_row(recon, U_BASE + BOT_OFF)};
      rcol_u_d = recon_rcol(recon, U_BASE);
      rcol_v_d = recon_rcol(recon, V_BASE);
    end

    if (load_left) begin
      lreg_u_d = rcol_u_q;
      lreg_v_d = rcol_v_q;
    end

    if (do_latch) begin
      top_u_d  = (y_q == '0) ? {8{TOP_EDGE}} : row_u;
      top_v_d  = (y_q == '0) ? {8{TOP_EDGE}} : row_v;
      left_u_d = (x_q == '0) ? {8{LEFT_EDGE}} : lreg_u_q;
      left_v_d = (x_q == '0) ? {8{LEFT_EDGE}} : lreg_v_q;
      top_left_u_d = (y_q == '0) ? TOP_EDGE : ((x_q == '0) ? LEFT_EDGE : tl_u_q);
      top_left_v_d = (y_q == '0) ? TOP_EDGE : ((x_q == '0) ? LEFT_EDGE : tl_v_q);
      // Last top byte of this column becomes the corner for column x+1
      tl_u_d = row_u[ROW_W-1 -: BYTE_W];
      tl_v_d = row_v[ROW_W-1 -: BYTE_W];
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      pend_q       <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      bot_q        <= '0;
      rcol_u_q     <= '0;
      rcol_v_q     <= '0;
      lreg_u_q     <= '0;
      lreg_v_q     <= '0;
      tl_u_q       <= '0;
      tl_v_q       <= '0;
      top_u_q      <= '0;
      top_v_q      <= '0;
      left_u_q     <= '0;
      left_v_q     <= '0;
      top_left_u_q <= '0;
      top_left_v_q <= '0;
      ctx_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pend_q       <= pend_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      bot_q        <= bot_d;
      rcol_u_q     <= rcol_u_d;
      rcol_v_q     <= rcol_v_d;
      lreg_u_q     <= lreg_u_d;
      lreg_v_q     <= lreg_v_d;
      tl_u_q       <= tl_u_d;
      tl_v_q       <= tl_v_d;
      top_u_q      <= top_u_d;
      top_v_q      <= top_v_d;
      left_u_q     <= left_u_d;
      left_v_q     <= left_v_d;
      top_left_u_q <= top_left_u_d;
      top_left_v_q <= top_left_v_d;
      ctx_valid_q  <= ctx_valid_d;
      busy_q       <= busy_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign top_u      = top_u_q;
  assign top_v      = top_v_q;
  assign left_u     = left_u_q;
  assign left_v     = left_v_q;
  assign top_left_u = top_left_u_q;
  assign top_left_v = top_left_v_q;
  assign ctx_valid  = ctx_valid_q;
  assign busy       = busy_q;
  assign proto_err  = proto_err_q;

endmodule
